// File: rtl/uno_kb_pkg.sv
// Shared constants and types for the keyboard-driven turn controller:
// PS/2 set-2 scancodes, command encodings, FSM state encodings and the
// player-rotation arithmetic.
package uno_kb_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BRK       = 8'hF0;

    // Make codes of interest
    localparam logic [7:0] SC_LEFT      = 8'h1C;  // 'A'
    localparam logic [7:0] SC_RIGHT     = 8'h23;  // 'D'
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;  // E0-prefixed arrow left
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;  // E0-prefixed arrow right
    localparam logic [7:0] SC_PLAY      = 8'h5A;  // Enter
    localparam logic [7:0] SC_DRAW      = 8'h29;  // Space

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_PLAY = 2'b01,
        CMD_DRAW = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_e;

    typedef enum logic [1:0] {
        SEQ_READY     = 2'd0,
        SEQ_PEND      = 2'd1,
        SEQ_WAIT_TURN = 2'd2
    } seq_state_e;

    // Step the player index by 1 or 2 in the given direction, modulo n.
    // A 3-bit intermediate holds player+step (max 5) and player+n-step
    // (max 6) so a single conditional subtract gives the exact residue.
    function automatic logic [1:0] next_player(
        input logic [1:0] player,
        input logic       skip,
        input logic       dir,
        input logic [2:0] n
    );
        logic [2:0] step;
        logic [2:0] sum;
        step = skip ? 3'd2 : 3'd1;
        if (!dir) begin
            sum = {1'b0, player} + step;
        end else begin
            sum = {1'b0, player} + n - step;
        end
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/ps2_prefix_decoder.sv
// Tracks E0/F0 prefixes of a PS/2 set-2 byte stream and emits a one-cycle
// key pulse in the same cycle as the strobe carrying the final make byte.
// Break sequences and unmapped codes produce no pulse.
module ps2_prefix_decoder
    import uno_kb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_code,
    input  logic       i_code_vld,
    output logic       o_left,
    output logic       o_right,
    output logic       o_play,
    output logic       o_draw
);

    dec_state_e r_state;
    dec_state_e w_state_nxt;

    // Prefix state register.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= DEC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next prefix state and combinational key pulses; only a strobe moves anything.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case statements can infer a latch.
        w_state_nxt = r_state;
        o_left      = 1'b0;
        o_right     = 1'b0;
        o_play      = 1'b0;
        o_draw      = 1'b0;
        if (i_code_vld) begin
            case (r_state)
                DEC_IDLE: begin
                    if (i_code == SC_BRK) begin
                        w_state_nxt = DEC_BRK;
                    end else if (i_code == SC_EXT) begin
                        w_state_nxt = DEC_EXT;
                    end else begin
                        o_left  = (i_code == SC_LEFT);
                        o_right = (i_code == SC_RIGHT);
                        o_play  = (i_code == SC_PLAY);
                        o_draw  = (i_code == SC_DRAW);
                    end
                end
                DEC_EXT: begin
                    if (i_code == SC_BRK) begin
                        w_state_nxt = DEC_EXT_BRK;
                    end else begin
                        w_state_nxt = DEC_IDLE;
                        o_left      = (i_code == SC_EXT_LEFT);
                        o_right     = (i_code == SC_EXT_RIGHT);
                    end
                end
                default: begin
                    // Byte after F0 (plain or extended) is a release: swallow it.
                    w_state_nxt = DEC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/kb_turn_controller.sv
// Keyboard front end for a card-game turn: moves a card cursor, issues
// PLAY/DRAW commands to the game engine with a valid/ready handshake, and
// rotates the active player when the engine ends the turn.
module kb_turn_controller
    import uno_kb_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int HAND_W    = 5
)
(
    input  logic              CLOCK_50,
    input  logic              i_rst,
    input  logic [7:0]        i_code,
    input  logic              i_code_vld,
    input  logic [HAND_W-1:0] i_hand_size,
    input  logic              i_cmd_rdy,
    input  logic              i_advance,
    input  logic              i_skip,
    input  logic              i_reverse,
    output logic [1:0]        o_cmd,
    output logic              o_cmd_vld,
    output logic [HAND_W-1:0] o_card,
    output logic [HAND_W-1:0] o_cursor,
    output logic [1:0]        o_player,
    output logic              o_dir,
    output logic              o_drop
);

    localparam logic [2:0]        N_P     = 3'(N_PLAYERS);
    localparam logic [HAND_W-1:0] CUR_ONE = HAND_W'(1);

    logic w_left;
    logic w_right;
    logic w_play;
    logic w_draw;

    seq_state_e        r_state,   w_state_nxt;
    cmd_e              r_cmd,     w_cmd_nxt;
    logic              r_cmd_vld, w_cmd_vld_nxt;
    logic [HAND_W-1:0] r_card,    w_card_nxt;
    logic [HAND_W-1:0] r_cursor,  w_cursor_nxt;
    logic [1:0]        r_player,  w_player_nxt;
    logic              r_dir,     w_dir_nxt;
    logic              r_drop,    w_drop_nxt;

    logic [HAND_W-1:0] w_hand_last;
    logic [HAND_W-1:0] w_cur_eff;
    logic              w_hand_empty;

    ps2_prefix_decoder u_decoder (
        .i_clk      (CLOCK_50),
        .i_rst      (i_rst),
        .i_code     (i_code),
        .i_code_vld (i_code_vld),
        .o_left     (w_left),
        .o_right    (w_right),
        .o_play     (w_play),
        .o_draw     (w_draw)
    );

    // Cursor as it should be for the current hand: clamped into range, or 0 for an empty hand.
    always_comb begin
        w_hand_empty = (i_hand_size == '0);
        w_hand_last  = i_hand_size - CUR_ONE;
        if (w_hand_empty) begin
            w_cur_eff = '0;
        end else if (r_cursor >= i_hand_size) begin
            w_cur_eff = w_hand_last;
        end else begin
            w_cur_eff = r_cursor;
        end
    end

    // Sequencer next-state: turn advance first, then per-state key and handshake handling.
    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_cmd_vld_nxt = r_cmd_vld;
        w_card_nxt    = r_card;
        w_cursor_nxt  = w_cur_eff;
        w_player_nxt  = r_player;
        w_dir_nxt     = r_dir;
        w_drop_nxt    = 1'b0;

        if (i_advance) begin
            // Ending the turn overrides any key or handshake arriving with it.
            w_dir_nxt     = r_dir ^ i_reverse;
            w_player_nxt  = next_player(r_player, i_skip, w_dir_nxt, N_P);
            w_cursor_nxt  = '0;
            w_cmd_nxt     = CMD_NONE;
            w_cmd_vld_nxt = 1'b0;
            w_state_nxt   = SEQ_READY;
        end else begin
            case (r_state)
                SEQ_READY: begin
                    if (w_left) begin
                        if (w_hand_empty) begin
                            w_cursor_nxt = '0;
                        end else if (w_cur_eff == '0) begin
                            w_cursor_nxt = w_hand_last;
                        end else begin
                            w_cursor_nxt = w_cur_eff - CUR_ONE;
                        end
                    end else if (w_right) begin
                        if (w_hand_empty || (w_cur_eff == w_hand_last)) begin
                            w_cursor_nxt = '0;
                        end else begin
                            w_cursor_nxt = w_cur_eff + CUR_ONE;
                        end
                    end else if (w_play) begin
                        if (w_hand_empty) begin
                            w_drop_nxt = 1'b1;
                        end else begin
                            w_cmd_nxt     = CMD_PLAY;
                            w_card_nxt    = w_cur_eff;
                            w_cmd_vld_nxt = 1'b1;
                            w_state_nxt   = SEQ_PEND;
                        end
                    end else if (w_draw) begin
                        w_cmd_nxt     = CMD_DRAW;
                        w_cmd_vld_nxt = 1'b1;
                        w_state_nxt   = SEQ_PEND;
                    end
                end
                SEQ_PEND: begin
                    if (r_cmd_vld && i_cmd_rdy) begin
                        w_cmd_nxt     = CMD_NONE;
                        w_cmd_vld_nxt = 1'b0;
                        w_state_nxt   = SEQ_WAIT_TURN;
                    end
                    if (w_play || w_draw) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                SEQ_WAIT_TURN: begin
                    if (w_play || w_draw) begin
                        w_drop_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SEQ_READY;
                end
            endcase
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (i_rst) begin
            r_state   <= SEQ_READY;
            r_cmd     <= CMD_NONE;
            r_cmd_vld <= 1'b0;
            r_card    <= '0;
            r_cursor  <= '0;
            r_player  <= '0;
            r_dir     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cmd_vld <= w_cmd_vld_nxt;
            r_card    <= w_card_nxt;
            r_cursor  <= w_cursor_nxt;
            r_player  <= w_player_nxt;
            r_dir     <= w_dir_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign o_cmd     = r_cmd;
    assign o_cmd_vld = r_cmd_vld;
    assign o_card    = r_card;
    assign o_cursor  = r_cursor;
    assign o_player  = r_player;
    assign o_dir     = r_dir;
    assign o_drop    = r_drop;

endmodule
